// File: rtl/dev_bus_pkg.sv
// Shared types and default address map for the CPU-side device bus router.
package dev_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_e;

  localparam int SLV_RAM    = 0;
  localparam int SLV_ROM    = 1;
  localparam int SLV_GPU    = 2;
  localparam int SLV_UART   = 3;
  localparam int SLV_GPIO   = 4;
  localparam int SLV_TICKER = 5;

  localparam logic [31:0] RAM_BASE    = 32'h0000_0000;
  localparam logic [31:0] ROM_BASE    = 32'h1E00_0000;
  localparam logic [31:0] GPU_BASE    = 32'h1B00_0000;
  localparam logic [31:0] UART_BASE   = 32'h1FD0_03F0;
  localparam logic [31:0] GPIO_BASE   = 32'h1FD0_0400;
  localparam logic [31:0] TICKER_BASE = 32'h1FD0_0500;

  localparam logic [31:0] RAM_MASK    = 32'hFF00_0000;
  localparam logic [31:0] ROM_MASK    = 32'hFF00_0000;
  localparam logic [31:0] GPU_MASK    = 32'hFF00_0000;
  localparam logic [31:0] UART_MASK   = 32'hFFFF_FFF0;
  localparam logic [31:0] GPIO_MASK   = 32'hFFFF_FF00;
  localparam logic [31:0] TICKER_MASK = 32'hFFFF_FF00;

  // Slot i lives at bits [i*32 +: 32], so the highest slot is written first.
  localparam logic [6*32-1:0] DEFAULT_BASE =
    {TICKER_BASE, GPIO_BASE, UART_BASE, GPU_BASE, ROM_BASE, RAM_BASE};
  localparam logic [6*32-1:0] DEFAULT_MASK =
    {TICKER_MASK, GPIO_MASK, UART_MASK, GPU_MASK, ROM_MASK, RAM_MASK};

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dev_bus_decode.sv
// Base/mask window compare for every slave, resolved by lowest-index priority.
module dev_bus_decode
  import dev_bus_pkg::*;
#(
  parameter int                           NUM_SLAVES = 6,
  parameter int                           ADDR_W     = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = '0,
  localparam int                          IDX_W      = idx_width(NUM_SLAVES)
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [IDX_W-1:0]  idx,
  output logic [ADDR_W-1:0] offset
);

  logic [NUM_SLAVES-1:0] match;

  for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_match
    assign match[i] =
      ((addr ^ SLAVE_BASE[i*ADDR_W +: ADDR_W]) & SLAVE_MASK[i*ADDR_W +: ADDR_W]) == '0;
  end

  // NOTE: every output gets a default before the loop so no path leaves one unassigned (no latch).
  always_comb begin
    hit    = 1'b0;
    idx    = '0;
    offset = '0;
    // Walking downward lets the lowest matching index overwrite the others.
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit    = 1'b1;
        idx    = IDX_W'(i);
        offset = addr & ~SLAVE_MASK[i*ADDR_W +: ADDR_W];
      end
    end
  end

endmodule

// File: rtl/dev_bus_router.sv
// Registered stall-based router from the CPU data port to NUM_SLAVES peripherals,
// with slave-ready handshake, access timeout and bus-error response.
module dev_bus_router
  import dev_bus_pkg::*;
#(
  parameter int                           NUM_SLAVES     = 6,
  parameter int                           ADDR_W         = 32,
  parameter int                           DATA_W         = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE     = DEFAULT_BASE,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK     = DEFAULT_MASK,
  parameter int                           TIMEOUT_CYCLES = 255,
  localparam int                          BE_W           = DATA_W / 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_W-1:0]            m_addr,
  input  logic [BE_W-1:0]              m_be,
  input  logic                         m_read,
  input  logic                         m_write,
  input  logic [DATA_W-1:0]            m_wdata,
  output logic [DATA_W-1:0]            m_rdata,
  output logic                         m_stall,
  output logic                         m_err,
  output logic [ADDR_W-1:0]            s_addr,
  output logic [BE_W-1:0]              s_be,
  output logic [DATA_W-1:0]            s_wdata,
  output logic [NUM_SLAVES-1:0]        s_read,
  output logic [NUM_SLAVES-1:0]        s_write,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
  input  logic [NUM_SLAVES-1:0]        s_ready
);

  localparam int IDX_W = idx_width(NUM_SLAVES);
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e                  state;
  logic [IDX_W-1:0]        sel;
  logic [CNT_W-1:0]        cnt;
  logic                    dec_hit;
  logic [IDX_W-1:0]        dec_idx;
  logic [ADDR_W-1:0]       dec_offset;
  logic [NUM_SLAVES-1:0]   dec_oh;

  dev_bus_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_W     (ADDR_W),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_decode (
    .addr   (m_addr),
    .hit    (dec_hit),
    .idx    (dec_idx),
    .offset (dec_offset)
  );

  assign dec_oh = NUM_SLAVES'(1) << dec_idx;

  // Stall is combinational in IDLE so the master holds the very first request cycle.
  assign m_stall = !rst && ((state == ST_IDLE) ? (m_read | m_write) : (state == ST_ACCESS));

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      sel     <= '0;
      cnt     <= '0;
      m_rdata <= '0;
      m_err   <= 1'b0;
      s_addr  <= '0;
      s_be    <= '0;
      s_wdata <= '0;
      s_read  <= '0;
      s_write <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (m_read || m_write) begin
            if (!dec_hit || (m_read && m_write)) begin
              state   <= ST_RESP;
              m_err   <= 1'b1;
              m_rdata <= '0;
            end else begin
              state   <= ST_ACCESS;
              sel     <= dec_idx;
              cnt     <= '0;
              s_addr  <= dec_offset;
              s_be    <= m_be;
              s_wdata <= m_wdata;
              s_read  <= m_read  ? dec_oh : '0;
              s_write <= m_write ? dec_oh : '0;
            end
          end
        end
        ST_ACCESS: begin
          if (s_ready[sel]) begin
            state   <= ST_RESP;
            m_err   <= 1'b0;
            m_rdata <= (|s_read) ? s_rdata[sel*DATA_W +: DATA_W] : '0;
            s_read  <= '0;
            s_write <= '0;
          end else if (cnt == CNT_LAST) begin
            state   <= ST_RESP;
            m_err   <= 1'b1;
            m_rdata <= '0;
            s_read  <= '0;
            s_write <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RESP: begin
          // The response is only presented for the one non-stalled cycle.
          state   <= ST_IDLE;
          m_err   <= 1'b0;
          m_rdata <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dev_bus_router.sv
// Self-checking bench for dev_bus_router: directed vector table, reset-mid-access
// sequence and randomized accesses scored against an address-map reference model.
module tb_dev_bus_router;

  localparam int NS = 6;
  localparam int TO = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      m_addr;
  logic [3:0]       m_be;
  logic             m_read;
  logic             m_write;
  logic [31:0]      m_wdata;
  logic [31:0]      m_rdata;
  logic             m_stall;
  logic             m_err;
  logic [31:0]      s_addr;
  logic [3:0]       s_be;
  logic [31:0]      s_wdata;
  logic [NS-1:0]    s_read;
  logic [NS-1:0]    s_write;
  logic [NS*32-1:0] s_rdata;
  logic [NS-1:0]    s_ready;

  int n_checks = 0;
  int n_err    = 0;

  // Bench map: slot 2 is the UART window, slot 3 a GPU window, and slot 4 aliases
  // slot 1 so the priority encoder has a real overlap to resolve.
  logic [31:0] map_base [NS] = '{32'h0000_0000, 32'h1E00_0000, 32'h1FD0_03F0,
                                 32'h1B00_0000, 32'h1E00_0000, 32'h1FD0_0500};
  logic [31:0] map_mask [NS] = '{32'hFF00_0000, 32'hFF00_0000, 32'hFFFF_FFF0,
                                 32'hFF00_0000, 32'hFFFF_FF00, 32'hFFFF_FF00};

  dev_bus_router #(
    .NUM_SLAVES     (NS),
    .ADDR_W         (32),
    .DATA_W         (32),
    .SLAVE_BASE     ({32'h1FD0_0500, 32'h1E00_0000, 32'h1B00_0000,
                      32'h1FD0_03F0, 32'h1E00_0000, 32'h0000_0000}),
    .SLAVE_MASK     ({32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFF00_0000,
                      32'hFFFF_FFF0, 32'hFF00_0000, 32'hFF00_0000}),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .m_addr  (m_addr),
    .m_be    (m_be),
    .m_read  (m_read),
    .m_write (m_write),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata),
    .m_stall (m_stall),
    .m_err   (m_err),
    .s_addr  (s_addr),
    .s_be    (s_be),
    .s_wdata (s_wdata),
    .s_read  (s_read),
    .s_write (s_write),
    .s_rdata (s_rdata),
    .s_ready (s_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   addr;
    logic [3:0]    be;
    logic          rd;
    logic          wr;
    logic [31:0]   wdata;
    int            delay;      // wait cycles before ready; >= TO means never in time
    logic [31:0]   sdata;
    logic [NS-1:0] exp_oh;     // selected slave, zero for a decode error
    logic [31:0]   exp_saddr;
    int            exp_stalls;
    logic          exp_err;
    logic [31:0]   exp_rdata;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] addr, input logic [3:0] be, input logic rd,
                              input logic wr, input logic [31:0] wdata, input int delay,
                              input logic [31:0] sdata, input logic [NS-1:0] oh,
                              input logic [31:0] saddr, input int stalls, input logic err,
                              input logic [31:0] rdata);
    vec_t v;
    v.addr = addr; v.be = be; v.rd = rd; v.wr = wr; v.wdata = wdata; v.delay = delay;
    v.sdata = sdata; v.exp_oh = oh; v.exp_saddr = saddr; v.exp_stalls = stalls;
    v.exp_err = err; v.exp_rdata = rdata;
    return v;
  endfunction

  // Reference model: walk the address map in priority order, then derive the
  // transaction outcome from the handshake rules.
  function automatic vec_t model(input logic [31:0] addr, input logic [3:0] be, input logic rd,
                                 input logic wr, input logic [31:0] wdata, input int delay,
                                 input logic [31:0] sdata);
    vec_t v;
    int   idx = -1;
    for (int i = 0; i < NS; i++)
      if (idx < 0 && ((addr ^ map_base[i]) & map_mask[i]) == 32'h0) idx = i;
    v = mk(addr, be, rd, wr, wdata, delay, sdata, '0, '0, 1, 1'b1, '0);
    if (idx >= 0 && !(rd && wr)) begin
      v.exp_oh    = NS'(1) << idx;
      v.exp_saddr = addr & ~map_mask[idx];
      if (delay < TO) begin
        v.exp_stalls = delay + 2;
        v.exp_err    = 1'b0;
        v.exp_rdata  = rd ? sdata : 32'h0;
      end else begin
        v.exp_stalls = TO + 1;
      end
    end
    return v;
  endfunction

  // Entered just after a falling edge; returns just after the falling edge that
  // follows the response cycle, with the request already withdrawn.
  task automatic run_txn(input vec_t v, input string tag);
    int   stalls  = 0;
    int   strobes = 0;
    int   cyc     = 0;
    bit   done    = 0;
    bit   shape   = 1;
    logic rsp_err   = 1'b0;
    logic [31:0] rsp_rdata = '0;
    m_addr  = v.addr;
    m_be    = v.be;
    m_read  = v.rd;
    m_write = v.wr;
    m_wdata = v.wdata;
    for (int s = 0; s < NS; s++) s_rdata[s*32 +: 32] = v.exp_oh[s] ? v.sdata : $urandom;
    while (!done && cyc < 40) begin
      s_ready = NS'($urandom) & ~v.exp_oh;
      #1;
      if (|(s_read | s_write)) begin
        strobes++;
        if (s_read !== (v.rd ? v.exp_oh : '0) || s_write !== (v.wr ? v.exp_oh : '0) ||
            s_addr !== v.exp_saddr || s_be !== v.be || s_wdata !== v.wdata)
          shape = 0;
        if (strobes == v.delay + 1) s_ready = s_ready | v.exp_oh;
        m_addr  = $urandom;
        m_wdata = $urandom;
        m_be    = 4'($urandom);
      end
      if (m_stall) stalls++;
      else begin
        rsp_err   = m_err;
        rsp_rdata = m_rdata;
        done      = 1;
      end
      cyc++;
      @(negedge clk);
    end
    m_read  = 1'b0;
    m_write = 1'b0;
    s_ready = '0;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_stalls"}, stalls, v.exp_stalls);
    check({tag, "_strobe_cycles"}, strobes, (v.exp_oh == '0) ? 0 : v.exp_stalls - 1);
    check({tag, "_strobe_shape"}, 32'(shape), 32'd1);
    check({tag, "_err"}, 32'(rsp_err), 32'(v.exp_err));
    check({tag, "_rdata"}, rsp_rdata, v.exp_rdata);
  endtask

  vec_t tbl [11];

  initial begin
    tbl[0]  = mk(32'h0000_0010, 4'hF, 1, 0, 32'h0,  0,   32'hDEAD_BEEF, 6'b000001, 32'h10, 2, 0, 32'hDEAD_BEEF);
    tbl[1]  = mk(32'h1FD0_03F8, 4'h1, 0, 1, 32'h41, 3,   32'h1111_1111, 6'b000100, 32'h8,  5, 0, 32'h0);
    tbl[2]  = mk(32'h1E00_0004, 4'hF, 1, 0, 32'h0,  1,   32'h1234_5678, 6'b000010, 32'h4,  3, 0, 32'h1234_5678);
    tbl[3]  = mk(32'h8000_0000, 4'hF, 1, 0, 32'h0,  0,   32'h5555_5555, 6'b000000, 32'h0,  1, 1, 32'h0);
    tbl[4]  = mk(32'h0000_0000, 4'hF, 1, 1, 32'h7,  0,   32'h6666_6666, 6'b000000, 32'h0,  1, 1, 32'h0);
    tbl[5]  = mk(32'h1B00_0020, 4'hF, 1, 0, 32'h0,  100, 32'h7777_7777, 6'b001000, 32'h20, 5, 1, 32'h0);
    tbl[6]  = mk(32'h0000_0000, 4'hF, 1, 0, 32'h0,  0,   32'hCAFE_F00D, 6'b000001, 32'h0,  2, 0, 32'hCAFE_F00D);
    tbl[7]  = mk(32'h1B00_0004, 4'h3, 1, 0, 32'h0,  3,   32'hA5A5_0001, 6'b001000, 32'h4,  5, 0, 32'hA5A5_0001);
    tbl[8]  = mk(32'h1FD0_0510, 4'hC, 1, 0, 32'h0,  0,   32'h0BAD_CAFE, 6'b100000, 32'h10, 2, 0, 32'h0BAD_CAFE);
    tbl[9]  = mk(32'h1FD0_03F0, 4'hF, 0, 1, 32'h99, 4,   32'h0,         6'b000100, 32'h0,  5, 1, 32'h0);
    tbl[10] = mk(32'h1FD0_0400, 4'hF, 1, 0, 32'h0,  0,   32'h0,         6'b000000, 32'h0,  1, 1, 32'h0);

    rst = 1'b1;
    m_addr = '0; m_be = '0; m_read = 1'b1; m_write = 1'b0; m_wdata = '0;
    s_rdata = '0; s_ready = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("reset_stall", 32'(m_stall), 32'd0);
    check("reset_err", 32'(m_err), 32'd0);
    check("reset_rdata", m_rdata, 32'h0);
    check("reset_strobes", 32'({s_read, s_write}), 32'h0);
    check("reset_saddr", s_addr, 32'h0);
    check("reset_swdata", 32'({s_be, s_wdata}), 32'h0);
    m_read = 1'b0;
    rst    = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 11; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    // Reset lands in the second ACCESS cycle of a never-ready access.
    m_addr = 32'h1B00_0000; m_read = 1'b1; m_be = 4'hF;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_mid_strobe_before", 32'(s_read), 32'b001000);
    rst = 1'b1;
    #1;
    check("rst_mid_stall_during", 32'(m_stall), 32'd0);
    @(negedge clk);
    #1;
    check("rst_mid_strobes_after", 32'({s_read, s_write}), 32'h0);
    check("rst_mid_err_after", 32'(m_err), 32'd0);
    rst = 1'b0; m_read = 1'b0;
    @(negedge clk);
    #1;
    check("rst_mid_idle_stall", 32'(m_stall), 32'd0);
    check("rst_mid_idle_err", 32'(m_err), 32'd0);
    @(negedge clk);
    run_txn(tbl[0], "post_rst");

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      logic        rd, wr;
      int          k;
      case ($urandom_range(0, 7))
        0:       a = {8'h00, 24'($urandom)};
        1:       a = {8'h1E, 24'($urandom)};
        2:       a = {28'h1FD_003F, 4'($urandom)};
        3:       a = {8'h1B, 24'($urandom)};
        4:       a = {24'h1FD_005, 8'($urandom)};
        5:       a = {28'h1FD_003E, 4'($urandom)};
        6:       a = $urandom;
        default: a = {24'h1E_0000, 8'($urandom)};
      endcase
      k  = $urandom_range(0, 9);
      rd = (k == 0) || (k < 5);
      wr = (k == 0) || (k >= 5);
      run_txn(model(a, 4'($urandom), rd, wr, $urandom, $urandom_range(0, 5), $urandom),
              $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
